// File: rtl/pc_pkg.sv
// Shared definitions for the program counter: next-PC select encoding and default geometry.
// Stack build option: PC_STACK_EN (see program_counter.sv).
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_INC    = 2'd1,
        SEL_TARGET = 2'd2,
        SEL_POP    = 2'd3
    } pc_sel_e;

    localparam int PC_ADDR_W_DEF      = 4;
    localparam int PC_STACK_DEPTH_DEF = 4;
    localparam int PC_RESET_VEC_DEF   = 0;

endpackage

// File: rtl/program_counter_if.sv
// Decoder/ALU-facing bundle of the program counter: control requests in, address and stack status out.
interface program_counter_if
    import pc_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W_DEF
);
    logic              en;
    logic              jmp;
    logic              jc;
    logic              jz;
    logic              c_flag;
    logic              z_flag;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic              stack_empty;
    logic              stack_full;
    logic              fault;

    modport master (
        output en, jmp, jc, jz, c_flag, z_flag, call, ret, target,
        input  pc, stack_empty, stack_full, fault
    );

    modport slave (
        input  en, jmp, jc, jz, c_flag, z_flag, call, ret, target,
        output pc, stack_empty, stack_full, fault
    );
endinterface

// File: rtl/pc_return_stack.sv
// LIFO of return addresses with registered pointer and empty/full flags.
// Pop data is the current top entry, read combinationally so pop and PC load share one edge.
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W      = PC_ADDR_W_DEF,
    parameter int STACK_DEPTH = PC_STACK_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] pop_data,
    output logic              empty,
    output logic              full
);
    localparam int                PTR_W   = $clog2(STACK_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] entry_reg [STACK_DEPTH];
    logic [PTR_W-1:0]  sp_reg;
    logic [PTR_W-1:0]  sp_next;
    logic [PTR_W-1:0]  top_ptr;
    logic              empty_reg;
    logic              full_reg;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full_reg;
    assign do_pop  = pop && !empty_reg && !push;
    assign top_ptr = sp_reg - PTR_ONE;

    always_comb begin
        sp_next = sp_reg;
        if (do_push) begin
            sp_next = sp_reg + PTR_ONE;
        end else if (do_pop) begin
            sp_next = sp_reg - PTR_ONE;
        end
    end

    // Flags are registered from the next pointer so they line up with the updated PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_reg    <= '0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
        end else begin
            sp_reg    <= sp_next;
            empty_reg <= (sp_next == '0);
            full_reg  <= (sp_next == PTR_MAX);
        end
    end

    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && sp_reg == PTR_W'(gi)) begin
                    entry_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_comb begin
        pop_data = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (top_ptr == PTR_W'(i)) begin
                pop_data = entry_reg[i];
            end
        end
    end

    assign empty = empty_reg;
    assign full  = full_reg;

endmodule

// File: rtl/program_counter.sv
// Program counter with priority jump decode and optional call/return stack.
// Define PC_STACK_EN to build the return stack, call/ret and the sticky fault flag.
module program_counter
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = PC_ADDR_W_DEF,
    parameter int                STACK_DEPTH = PC_STACK_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(PC_RESET_VEC_DEF)
) (
    input logic              clk,
    input logic              reset,
    program_counter_if.slave bus
);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    pc_sel_e           sel;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pop_data;

    assign pc_inc = pc_reg + PC_ONE;

`ifdef PC_STACK_EN
    logic push;
    logic pop;
    logic fault_set;
    logic fault_reg;
    logic stack_empty;
    logic stack_full;

    // ret > call > jmp > jc > jz > increment; a blocked call/ret still advances the PC.
    always_comb begin
        sel       = SEL_HOLD;
        push      = 1'b0;
        pop       = 1'b0;
        fault_set = 1'b0;
        if (bus.en) begin
            if (bus.ret) begin
                if (!stack_empty) begin
                    sel = SEL_POP;
                    pop = 1'b1;
                end else begin
                    sel       = SEL_INC;
                    fault_set = 1'b1;
                end
            end else if (bus.call) begin
                if (!stack_full) begin
                    sel  = SEL_TARGET;
                    push = 1'b1;
                end else begin
                    sel       = SEL_INC;
                    fault_set = 1'b1;
                end
            end else if (bus.jmp) begin
                sel = SEL_TARGET;
            end else if (bus.jc) begin
                sel = bus.c_flag ? SEL_TARGET : SEL_INC;
            end else if (bus.jz) begin
                sel = bus.z_flag ? SEL_TARGET : SEL_INC;
            end else begin
                sel = SEL_INC;
            end
        end
    end

    pc_return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .pop_data  (pop_data),
        .empty     (stack_empty),
        .full      (stack_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_reg <= 1'b0;
        end else if (fault_set) begin
            fault_reg <= 1'b1;
        end
    end

    assign bus.stack_empty = stack_empty;
    assign bus.stack_full  = stack_full;
    assign bus.fault       = fault_reg;
`else
    logic unused_sig;

    // Without a stack, call degenerates to jmp and ret is ignored entirely.
    always_comb begin
        sel = SEL_HOLD;
        if (bus.en) begin
            if (bus.call || bus.jmp) begin
                sel = SEL_TARGET;
            end else if (bus.jc) begin
                sel = bus.c_flag ? SEL_TARGET : SEL_INC;
            end else if (bus.jz) begin
                sel = bus.z_flag ? SEL_TARGET : SEL_INC;
            end else begin
                sel = SEL_INC;
            end
        end
    end

    assign pop_data        = pc_reg;
    assign unused_sig      = bus.ret ^ (STACK_DEPTH > 0);
    assign bus.stack_empty = 1'b1;
    assign bus.stack_full  = 1'b0;
    assign bus.fault       = 1'b0;
`endif

    always_comb begin
        pc_next = pc_reg;
        case (sel)
            SEL_HOLD:   pc_next = pc_reg;
            SEL_INC:    pc_next = pc_inc;
            SEL_TARGET: pc_next = bus.target;
            SEL_POP:    pc_next = pop_data;
            default:    pc_next = pc_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= RESET_VEC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign bus.pc = pc_reg;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter against a queue-based model; covers both PC_STACK_EN builds.
module tb_program_counter;
    localparam int AW    = 4;
    localparam int DEPTH = 2;
    localparam int RV    = 3;
    localparam int MOD   = 1 << AW;

    localparam bit [7:0] EN   = 8'h80;
    localparam bit [7:0] JMP  = 8'h40;
    localparam bit [7:0] JC   = 8'h20;
    localparam bit [7:0] JZ   = 8'h10;
    localparam bit [7:0] CF   = 8'h08;
    localparam bit [7:0] ZF   = 8'h04;
    localparam bit [7:0] CALL = 8'h02;
    localparam bit [7:0] RET  = 8'h01;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_on = 1'b0;

    int   m_pc;
    int   m_stack[$];
    bit   m_fault;

    program_counter_if #(.ADDR_W(AW)) bus();

    program_counter #(
        .ADDR_W      (AW),
        .STACK_DEPTH (DEPTH),
        .RESET_VEC   (4'd3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RV;
        m_stack.delete();
        m_fault = 1'b0;
    endtask

    function automatic int exp_empty();
`ifdef PC_STACK_EN
        return (m_stack.size() == 0) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    function automatic int exp_full();
`ifdef PC_STACK_EN
        return (m_stack.size() == DEPTH) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic model_step(input bit [7:0] ctl, input int tgt);
        int inc;
        int t;
        inc = (m_pc + 1) % MOD;
        t   = tgt % MOD;
        if ((ctl & EN) == 0) return;
`ifdef PC_STACK_EN
        if ((ctl & RET) != 0) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_pc = inc; m_fault = 1'b1; end
        end else if ((ctl & CALL) != 0) begin
            if (m_stack.size() < DEPTH) begin m_stack.push_back(inc); m_pc = t; end
            else begin m_pc = inc; m_fault = 1'b1; end
        end else
`else
        if ((ctl & CALL) != 0) m_pc = t;
        else
`endif
        if ((ctl & JMP) != 0) m_pc = t;
        else if ((ctl & JC) != 0) m_pc = ((ctl & CF) != 0) ? t : inc;
        else if ((ctl & JZ) != 0) m_pc = ((ctl & ZF) != 0) ? t : inc;
        else m_pc = inc;
    endtask

    task automatic drive(input bit [7:0] ctl, input int tgt);
        bus.en     = ctl[7];
        bus.jmp    = ctl[6];
        bus.jc     = ctl[5];
        bus.jz     = ctl[4];
        bus.c_flag = ctl[3];
        bus.z_flag = ctl[2];
        bus.call   = ctl[1];
        bus.ret    = ctl[0];
        bus.target = tgt[AW-1:0];
    endtask

    // One enabled/disabled cycle; the line printed per transaction shows the resulting PC.
    task automatic step(input bit [7:0] ctl, input int tgt);
        @(negedge clk);
        drive(ctl, tgt);
        @(posedge clk);
        if (reset) model_step(ctl, tgt);
        #1;
        drive(8'h00, 0);
        $display("step ctl=%02h tgt=%0d -> pc=%0d empty=%0b full=%0b fault=%0b",
                 ctl, tgt, bus.pc, bus.stack_empty, bus.stack_full, bus.fault);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_reset_pc", int'(bus.pc), 3);
        chk("async_reset_empty", int'(bus.stack_empty), 1);
        chk("async_reset_fault", int'(bus.fault), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_pc", int'(bus.pc), m_pc);
            chk("model_empty", int'(bus.stack_empty), exp_empty());
            chk("model_full", int'(bus.stack_full), exp_full());
            chk("model_fault", int'(bus.fault), int'(m_fault));
        end
    end

    initial begin
        reset = 1'b0;
        drive(8'h00, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        cmp_on = 1'b1;
        chk("reset_pc", int'(bus.pc), 3);
        chk("reset_empty", int'(bus.stack_empty), 1);
        chk("reset_full", int'(bus.stack_full), 0);
        chk("reset_fault", int'(bus.fault), 0);

        repeat (6) step(EN, 0);
        chk("inc_to_9", int'(bus.pc), 9);
        async_reset();

        step(EN | JMP, 14);  chk("jmp_14", int'(bus.pc), 14);
        step(EN, 0);         chk("inc_15", int'(bus.pc), 15);
        step(EN, 0);         chk("wrap_0", int'(bus.pc), 0);
        step(EN, 0);         chk("inc_1", int'(bus.pc), 1);
        step(JMP | CALL, 9); chk("hold_1a", int'(bus.pc), 1);
        step(RET, 0);        chk("hold_1b", int'(bus.pc), 1);

        step(EN | JMP, 5);        chk("jmp_5", int'(bus.pc), 5);
        step(EN | JC, 12);        chk("jc_c0", int'(bus.pc), 6);
        step(EN | JMP, 5);
        step(EN | JC | CF, 12);   chk("jc_c1", int'(bus.pc), 12);
        step(EN | JMP, 5);
        step(EN | JZ | ZF, 12);   chk("jz_z1", int'(bus.pc), 12);
        step(EN | JMP, 5);
        step(EN | JZ, 12);        chk("jz_z0", int'(bus.pc), 6);
        step(EN | JMP | JC, 12);  chk("jmp_over_jc", int'(bus.pc), 12);
        step(EN | JC | JZ | ZF, 2); chk("jc_over_jz", int'(bus.pc), 13);

`ifdef PC_STACK_EN
        step(EN | JMP, 2);
        step(EN | CALL, 8);   chk("call_8", int'(bus.pc), 8);
        chk("call_8_empty", int'(bus.stack_empty), 0);
        step(EN | CALL, 13);  chk("call_13", int'(bus.pc), 13);
        chk("call_13_full", int'(bus.stack_full), 1);
        step(EN | RET, 0);    chk("ret_9", int'(bus.pc), 9);
        step(EN | RET, 0);    chk("ret_3", int'(bus.pc), 3);
        chk("ret_3_empty", int'(bus.stack_empty), 1);

        step(EN | CALL, 10);
        step(EN | CALL, 3);   chk("fill_full", int'(bus.stack_full), 1);
        step(EN | JMP, 4);
        step(EN | CALL, 9);   chk("ovf_pc", int'(bus.pc), 5);
        chk("ovf_fault", int'(bus.fault), 1);
        step(EN | RET, 0);    chk("ret_11", int'(bus.pc), 11);
        step(EN | RET, 0);    chk("ret_4", int'(bus.pc), 4);
        step(EN | JMP, 7);
        step(EN | RET, 0);    chk("unf_pc", int'(bus.pc), 8);
        chk("unf_fault", int'(bus.fault), 1);
        step(EN | JMP | CALL, 12); chk("call_over_jmp", int'(bus.pc), 12);
        step(RET, 0);         chk("hold_ret", int'(bus.pc), 12);
        step(EN | RET, 0);    chk("ret_after_prio", int'(bus.pc), 9);
        step(EN | CALL, 1);
        async_reset();
`else
        step(EN | JMP, 1);
        step(EN | CALL, 10);  chk("call_as_jmp", int'(bus.pc), 10);
        step(EN | RET, 0);    chk("ret_as_inc", int'(bus.pc), 11);
        chk("nostack_fault", int'(bus.fault), 0);
        chk("nostack_full", int'(bus.stack_full), 0);
        chk("nostack_empty", int'(bus.stack_empty), 1);
        step(EN | RET | JZ | ZF, 2); chk("ret_ignored", int'(bus.pc), 2);
        async_reset();
`endif
        step(EN, 0);          chk("post_reset_inc", int'(bus.pc), 4);

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_counter.md
# program_counter

Parametrised program counter for the microprocessor datapath, replacing the fixed 4-bit, 3-bit-load sequencer. Adds a configurable address width, unconditional, carry-conditional and zero-conditional jumps, and a hardware call/return stack. It drives the instruction-memory address and takes its controls from the decoder and flags from the ALU.

## Interface
- `ADDR_W`, 4: PC and target width, ≥2.
- `STACK_DEPTH`, 4: return-stack entries, ≥1.
- `RESET_VEC`, 0: PC value after reset, `ADDR_W` bits.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low; asserted (0) forces reset state immediately.
- `en`  in  1: advance enable; 0 holds all state.
- `jmp`  in  1: unconditional jump to `target`.
- `jc`  in  1: jump to `target` if `c_flag`.
- `jz`  in  1: jump to `target` if `z_flag`.
- `c_flag`, `z_flag`  in  1 each: ALU carry and zero flags.
- `call`  in  1: push return address, jump to `target`.
- `ret`  in  1: pop return address into PC.
- `target`  in  `ADDR_W`: jump/call destination, full width, no zero-extension.
- `pc`  out  `ADDR_W`: current program address, registered.
- `stack_empty`  out  1: no entries held.
- `stack_full`  out  1: `STACK_DEPTH` entries held.
- `fault`  out  1: sticky overflow/underflow indicator.

## Operation
- Reset (`reset`=0): `pc`=`RESET_VEC`, stack pointer 0, `stack_empty`=1, `stack_full`=0, `fault`=0.
- `en`=0: `pc`, stack and `fault` hold; all controls ignored.
- `en`=1, action chosen by fixed priority `ret` > `call` > `jmp` > `jc` > `jz` > increment:
  - `ret`, stack not empty: `pc` ← top entry, pointer −1.
  - `ret`, stack empty: underflow; `pc` ← `pc`+1, `fault` ← 1.
  - `call`, stack not full: push `pc`+1 (mod 2^`ADDR_W`), `pc` ← `target`, pointer +1.
  - `call`, stack full: overflow; no push, no jump, `pc` ← `pc`+1, `fault` ← 1.
  - `jmp`: `pc` ← `target`.
  - `jc`: `pc` ← `c_flag` ? `target` : `pc`+1.
  - `jz`: `pc` ← `z_flag` ? `target` : `pc`+1.
  - Otherwise: `pc` ← `pc`+1.
- Increment wraps: all-ones + 1 → 0. No carry out.
- A lower-priority request asserted together with a higher one is dropped and not remembered.
- `fault` is cleared only by reset.

## Timing
- All updates occur on the rising `clk` edge following the sampled controls. Next `pc` is visible one cycle after a request.
- Push and jump happen in the same edge. Pop and load happen in the same edge.
- `stack_empty` and `stack_full` are registered from the pointer and are valid in the same cycle as the updated `pc`.
- A back-to-back `call` then `ret` on consecutive enabled cycles returns to the `call` address + 1.
- Reset asserted mid-operation clears the stack and the PC asynchronously. Release is sampled synchronously to `clk` by the consuming logic.

## Configuration
- `PC_STACK_EN` defined: return stack, `call`, `ret` and `fault` are implemented as above.
- `PC_STACK_EN` undefined: no stack storage. `call` behaves as `jmp`. `ret` behaves as no request (increment). `stack_empty`=1, `stack_full`=0 and `fault`=0 are constant.

## Structure
- Shared package `pc_pkg`:
  - next-PC select encoding: `SEL_HOLD`, `SEL_INC`, `SEL_TARGET`, `SEL_POP`;
  - default `ADDR_W`, `STACK_DEPTH` and `RESET_VEC`.
- One sub-module, `pc_return_stack`: LIFO of `STACK_DEPTH` × `ADDR_W` with push/pop, pointer, empty and full flags. It is instantiated only under `PC_STACK_EN`.
- Top level holds the priority decode, next-PC mux and `fault` register.

## Test plan
- Reset: `ADDR_W`=4, `RESET_VEC`=3. Drive `reset`=0 mid-run with `pc`=9 → `pc`=3 immediately, `stack_empty`=1, `fault`=0.
- Increment and wrap: from `pc`=14 with `en`=1 for 3 cycles → 15, 0, 1. Then `en`=0 for 2 cycles → holds at 1.
- Conditional jumps: `pc`=5, `target`=12:
  - `jc` with `c_flag`=0 → 6;
  - `jc` with `c_flag`=1 → 12;
  - `jz` with `z_flag`=1 → 12.
- Nested call/return: `STACK_DEPTH`=2, `pc`=2.
  - `call` `target`=8 → 8;
  - `call` `target`=13 → 13, `stack_full`=1;
  - `ret` → 9;
  - `ret` → 3, `stack_empty`=1.
- Overflow, underflow and priority: with the stack full, `call` at `pc`=4 → `pc`=5, `fault`=1. With the stack empty, `ret` at `pc`=7 → 8, `fault` stays 1. `jmp`+`call` simultaneous with the stack not full → call wins, return address pushed.
- `PC_STACK_EN` undefined: `call` `target`=10 from `pc`=1 → 10. A following `ret` → 11. `fault` and `stack_full` stay 0, `stack_empty` stays 1.
